// File: rtl/exec_selwr_pkg.sv
// Shared exec write-back definitions: destination select,
// sequencer state and byte-lane enable encodings.
package exec_selwr_pkg;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_RF   = 2'd1;
    localparam logic [1:0] SEL_MEM  = 2'd2;
    localparam logic [1:0] SEL_BOTH = 2'd3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MEM1 = 2'd1;
    localparam logic [1:0] MEM2 = 2'd2;

    localparam logic [1:0] BE_LO = 2'b01;
    localparam logic [1:0] BE_HI = 2'b10;
    localparam logic [1:0] BE_W  = 2'b11;

    typedef struct packed {
        logic [1:0]  be;
        logic [15:0] data;
    } lane_t;

endpackage

// File: rtl/exec_lane_align.sv
// Places a result on the 16-bit memory bus lanes for the
// current store phase; odd word stores use two phases.
module exec_lane_align
    import exec_selwr_pkg::*;
(
    input  logic        iOdd,
    input  logic        iWord,
    input  logic        iPhase2,
    input  logic [15:0] iRes,
    output lane_t       oLane
);

    always_comb begin
        oLane = '0;
        unique case (1'b1)
            (!iWord && !iOdd): begin
                oLane.be   = BE_LO;
                oLane.data = {8'h00, iRes[7:0]};
            end
            (!iWord && iOdd): begin
                oLane.be   = BE_HI;
                oLane.data = {iRes[7:0], 8'h00};
            end
            (iWord && !iOdd): begin
                oLane.be   = BE_W;
                oLane.data = iRes;
            end
            (iWord && iOdd && !iPhase2): begin
                oLane.be   = BE_HI;
                oLane.data = {iRes[7:0], 8'h00};
            end
            (iWord && iOdd && iPhase2): begin
                oLane.be   = BE_LO;
                oLane.data = {8'h00, iRes[15:8]};
            end
            default: oLane = '0;
        endcase
    end

endmodule

// File: rtl/exec_selwr.sv
// Exec write-back sequencer: routes a result to the register
// file, the memory write bus, or both, stalling on memory.
module exec_selwr
    import exec_selwr_pkg::*;
#(
    parameter int AW = 20,
    parameter int DW = 16
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic          iValid,
    output logic          oReady,
    input  logic [1:0]    iSelOut,
    input  logic          iWordOp,
    input  logic [2:0]    iRegIdx,
    input  logic [DW-1:0] iRes,
    input  logic [AW-1:0] iAddr,
    output logic          oRfWe,
    output logic [2:0]    oRfIdx,
    output logic [DW-1:0] oRfData,
    output logic          oRfWord,
    output logic          oMemReq,
    output logic [AW-2:0] oMemAddr,
    output logic [DW-1:0] oMemData,
    output logic [1:0]    oMemBe,
    input  logic          iMemAck,
    output logic          oDone
);

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_res;
    logic          r_word;
    logic          r_rfWe;
    logic [2:0]    r_rfIdx;
    logic [DW-1:0] r_rfData;
    logic          r_rfWord;
    logic          r_done;

    logic          w_acc;
    logic          w_toRf;
    logic          w_toMem;
    logic          w_busy;
    logic          w_ack;
    logic          w_split;
    logic          w_last;
    logic [AW-2:0] w_wordAddr;
    logic [AW-2:0] w_nextAddr;
    lane_t         w_lane;

    assign w_toRf  = (iSelOut == SEL_RF) || (iSelOut == SEL_BOTH);
    assign w_toMem = (iSelOut == SEL_MEM) || (iSelOut == SEL_BOTH);

    assign oReady  = (r_state == IDLE);
    assign w_busy  = (r_state == MEM1) || (r_state == MEM2);
    assign w_acc   = iValid && oReady;
    assign w_ack   = w_busy && iMemAck;
    assign w_split = r_word && r_addr[0];
    assign w_last  = (r_state == MEM2) || !w_split;

    // Second half of a split store lands in the next word, wrapping.
    assign w_wordAddr = r_addr[AW-1:1];
    assign w_nextAddr = w_wordAddr + {{(AW-2){1'b0}}, 1'b1};

    exec_lane_align u_align (
        .iOdd    (r_addr[0]),
        .iWord   (r_word),
        .iPhase2 (r_state == MEM2),
        .iRes    (r_res),
        .oLane   (w_lane)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_acc && w_toMem) w_next = MEM1;
            MEM1: if (w_ack) w_next = w_split ? MEM2 : IDLE;
            MEM2: if (w_ack) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_res   <= '0;
            r_word  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_acc && !w_toMem) || (w_ack && w_last);
            if (w_acc) begin
                r_addr <= iAddr;
                r_res  <= iRes;
                r_word <= iWordOp;
            end
        end
    end

    // RF write runs independently of the memory sequence.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_rfWe   <= 1'b0;
            r_rfIdx  <= '0;
            r_rfData <= '0;
            r_rfWord <= 1'b0;
        end else begin
            r_rfWe <= w_acc && w_toRf;
            if (w_acc && w_toRf) begin
                r_rfIdx  <= iRegIdx;
                r_rfData <= iRes;
                r_rfWord <= iWordOp;
            end
        end
    end

    assign oRfWe   = r_rfWe;
    assign oRfIdx  = r_rfIdx;
    assign oRfData = r_rfData;
    assign oRfWord = r_rfWord;
    assign oDone   = r_done;

    assign oMemReq  = w_busy;
    assign oMemBe   = w_busy ? w_lane.be : 2'b00;
    assign oMemData = w_busy ? w_lane.data : '0;
    assign oMemAddr = (r_state == MEM2) ? w_nextAddr :
                      (r_state == MEM1) ? w_wordAddr : '0;

endmodule

// File: tb/tb_exec_selwr.sv
// Self-checking bench for exec_selwr: directed scenarios plus
// randomized transactions against a byte-level store model.
module tb_exec_selwr;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic        iValid;
    logic        oReady;
    logic [1:0]  iSelOut;
    logic        iWordOp;
    logic [2:0]  iRegIdx;
    logic [15:0] iRes;
    logic [19:0] iAddr;
    logic        oRfWe;
    logic [2:0]  oRfIdx;
    logic [15:0] oRfData;
    logic        oRfWord;
    logic        oMemReq;
    logic [18:0] oMemAddr;
    logic [15:0] oMemData;
    logic [1:0]  oMemBe;
    logic        iMemAck;
    logic        oDone;

    int n_vec = 0;
    int n_err = 0;

    logic [18:0] m_wa [2];
    logic [1:0]  m_be [2];
    logic [15:0] m_d  [2];
    int          m_nb;

    exec_selwr #(.AW(20), .DW(16)) dut (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iValid   (iValid),
        .oReady   (oReady),
        .iSelOut  (iSelOut),
        .iWordOp  (iWordOp),
        .iRegIdx  (iRegIdx),
        .iRes     (iRes),
        .iAddr    (iAddr),
        .oRfWe    (oRfWe),
        .oRfIdx   (oRfIdx),
        .oRfData  (oRfData),
        .oRfWord  (oRfWord),
        .oMemReq  (oMemReq),
        .oMemAddr (oMemAddr),
        .oMemData (oMemData),
        .oMemBe   (oMemBe),
        .iMemAck  (iMemAck),
        .oDone    (oDone)
    );

    always #5 iClk = ~iClk;

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic w,
                         input logic [2:0] idx, input logic [15:0] r,
                         input logic [19:0] a);
        iValid  = 1'b1;
        iSelOut = sel;
        iWordOp = w;
        iRegIdx = idx;
        iRes    = r;
        iAddr   = a;
    endtask

    // Model: list the bytes written, then group them per bus word.
    task automatic model(input logic [19:0] a, input logic w,
                         input logic [15:0] r);
        logic [19:0] x;
        logic [18:0] wa;
        logic [7:0]  v;
        int          lane;
        m_nb = 0;
        for (int i = 0; i < (w ? 2 : 1); i++) begin
            x    = a + 20'(i);
            wa   = x[19:1];
            lane = int'(x[0]);
            v    = (i == 0) ? r[7:0] : r[15:8];
            if (m_nb > 0 && m_wa[m_nb-1] == wa) begin
                m_be[m_nb-1] = m_be[m_nb-1] | 2'(1 << lane);
                m_d[m_nb-1]  = m_d[m_nb-1] | (16'(v) << (8 * lane));
            end else begin
                m_wa[m_nb] = wa;
                m_be[m_nb] = 2'(1 << lane);
                m_d[m_nb]  = 16'(v) << (8 * lane);
                m_nb++;
            end
        end
    endtask

    task automatic test_reset();
        iRst_n = 1'b0;
        step();
        n_vec++;
        if ({oReady, oRfWe, oMemReq, oDone, oMemBe} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_strobes: got %b want 100000",
                     {oReady, oRfWe, oMemReq, oDone, oMemBe});
        end
        n_vec++;
        if ({oMemAddr, oMemData, oRfIdx, oRfData, oRfWord} !== 55'd0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0",
                     {oMemAddr, oMemData, oRfIdx, oRfData, oRfWord});
        end
        iRst_n = 1'b1;
        step();
    endtask

    task automatic test_rf_only();
        drive(2'd1, 1'b1, 3'd3, 16'hBEEF, 20'h0ABCD);
        step();
        drive(2'd1, 1'b0, 3'd6, 16'h0042, 20'h00000);
        n_vec++;
        if ({oRfWe, oRfIdx, oRfData, oRfWord, oDone, oMemReq, oReady}
            !== {1'b1, 3'd3, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL rf_only: got we=%b idx=%0d d=%h w=%b done=%b req=%b rdy=%b want 1 3 beef 1 1 0 1",
                     oRfWe, oRfIdx, oRfData, oRfWord, oDone, oMemReq, oReady);
        end
        step();
        iValid = 1'b0;
        n_vec++;
        if ({oRfWe, oRfIdx, oRfData, oRfWord, oDone}
            !== {1'b1, 3'd6, 16'h0042, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL back_to_back: got we=%b idx=%0d d=%h w=%b done=%b want 1 6 0042 0 1",
                     oRfWe, oRfIdx, oRfData, oRfWord, oDone);
        end
        step();
        n_vec++;
        if ({oRfWe, oDone} !== 2'b00) begin
            n_err++;
            $display("FAIL rf_pulse_len: got %b want 00", {oRfWe, oDone});
        end
    endtask

    task automatic test_drop();
        drive(2'd0, 1'b1, 3'd1, 16'h7777, 20'h00002);
        step();
        iValid = 1'b0;
        n_vec++;
        if ({oDone, oRfWe, oMemReq, oReady} !== 4'b1001) begin
            n_err++;
            $display("FAIL sel_none: got %b want 1001",
                     {oDone, oRfWe, oMemReq, oReady});
        end
        step();
    endtask

    task automatic test_byte_store();
        drive(2'd2, 1'b0, 3'd0, 16'h0034, 20'h00101);
        step();
        iValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if ({oMemReq, oMemAddr, oMemBe, oMemData, oReady, oDone}
                !== {1'b1, 19'h00080, 2'b10, 16'h3400, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL byte_hold%0d: got req=%b a=%h be=%b d=%h rdy=%b done=%b want 1 00080 10 3400 0 0",
                         k, oMemReq, oMemAddr, oMemBe, oMemData, oReady, oDone);
            end
            if (k == 3) iMemAck = 1'b1;
            step();
        end
        iMemAck = 1'b0;
        n_vec++;
        if ({oDone, oMemReq, oReady} !== 3'b101) begin
            n_err++;
            $display("FAIL byte_done: got %b want 101", {oDone, oMemReq, oReady});
        end
        step();
        n_vec++;
        if (oDone !== 1'b0) begin
            n_err++;
            $display("FAIL byte_done_pulse: got %b want 0", oDone);
        end
    endtask

    task automatic test_split(input logic [19:0] a, input logic [15:0] r,
                              input logic [18:0] a1, input logic [15:0] d1,
                              input logic [18:0] a2, input logic [15:0] d2);
        drive(2'd2, 1'b1, 3'd0, r, a);
        iMemAck = 1'b1;
        step();
        iValid = 1'b0;
        n_vec++;
        if ({oMemReq, oMemAddr, oMemBe, oMemData} !== {1'b1, a1, 2'b10, d1}) begin
            n_err++;
            $display("FAIL split_lo: got req=%b a=%h be=%b d=%h want 1 %h 10 %h",
                     oMemReq, oMemAddr, oMemBe, oMemData, a1, d1);
        end
        step();
        n_vec++;
        if ({oMemReq, oMemAddr, oMemBe, oMemData, oDone}
            !== {1'b1, a2, 2'b01, d2, 1'b0}) begin
            n_err++;
            $display("FAIL split_hi: got req=%b a=%h be=%b d=%h done=%b want 1 %h 01 %h 0",
                     oMemReq, oMemAddr, oMemBe, oMemData, oDone, a2, d2);
        end
        step();
        iMemAck = 1'b0;
        n_vec++;
        if ({oDone, oMemReq, oReady} !== 3'b101) begin
            n_err++;
            $display("FAIL split_done: got %b want 101", {oDone, oMemReq, oReady});
        end
    endtask

    task automatic test_both();
        drive(2'd3, 1'b1, 3'd5, 16'h1234, 20'h00010);
        iMemAck = 1'b1;
        step();
        iValid  = 1'b0;
        iMemAck = 1'b0;
        n_vec++;
        if ({oRfWe, oRfIdx, oRfData, oMemReq, oMemAddr, oMemBe, oMemData, oDone}
            !== {1'b1, 3'd5, 16'h1234, 1'b1, 19'h00008, 2'b11, 16'h1234, 1'b0}) begin
            n_err++;
            $display("FAIL both_first: got we=%b idx=%0d rd=%h req=%b a=%h be=%b d=%h done=%b",
                     oRfWe, oRfIdx, oRfData, oMemReq, oMemAddr, oMemBe, oMemData, oDone);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            n_vec++;
            if ({oRfWe, oMemReq, oMemAddr, oMemBe, oDone}
                !== {1'b0, 1'b1, 19'h00008, 2'b11, 1'b0}) begin
                n_err++;
                $display("FAIL both_wait%0d: got we=%b req=%b a=%h be=%b done=%b want 0 1 00008 11 0",
                         k, oRfWe, oMemReq, oMemAddr, oMemBe, oDone);
            end
        end
        iMemAck = 1'b1;
        step();
        iMemAck = 1'b0;
        n_vec++;
        if ({oDone, oMemReq, oReady} !== 3'b101) begin
            n_err++;
            $display("FAIL both_done: got %b want 101", {oDone, oMemReq, oReady});
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive(2'd2, 1'b1, 3'd0, 16'hCAFE, 20'h00011);
        step();
        iValid  = 1'b0;
        iMemAck = 1'b1;
        step();
        iMemAck = 1'b0;
        n_vec++;
        if ({oMemReq, oMemAddr, oMemBe} !== {1'b1, 19'h00009, 2'b01}) begin
            n_err++;
            $display("FAIL rstmid_mem2: got req=%b a=%h be=%b want 1 00009 01",
                     oMemReq, oMemAddr, oMemBe);
        end
        #2;
        iRst_n = 1'b0;
        #1;
        n_vec++;
        if ({oMemReq, oReady, oMemBe} !== 4'b0100) begin
            n_err++;
            $display("FAIL rstmid_async: got %b want 0100", {oMemReq, oReady, oMemBe});
        end
        step();
        iRst_n = 1'b1;
        step();
        n_vec++;
        if ({oDone, oReady, oMemReq} !== 3'b010) begin
            n_err++;
            $display("FAIL rstmid_after: got %b want 010", {oDone, oReady, oMemReq});
        end
        drive(2'd1, 1'b0, 3'd2, 16'h00AB, 20'h00000);
        step();
        iValid = 1'b0;
        n_vec++;
        if ({oRfWe, oRfIdx, oRfData, oRfWord, oDone}
            !== {1'b1, 3'd2, 16'h00AB, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL rstmid_rf: got we=%b idx=%0d d=%h w=%b done=%b want 1 2 00ab 0 1",
                     oRfWe, oRfIdx, oRfData, oRfWord, oDone);
        end
        step();
    endtask

    task automatic test_random(input int n);
        logic [1:0]  sel;
        logic        w;
        logic [2:0]  idx;
        logic [15:0] r;
        logic [19:0] a;
        logic        first;
        int          wt;
        for (int t = 0; t < n; t++) begin
            sel = 2'($urandom_range(0, 3));
            w   = 1'($urandom_range(0, 1));
            idx = 3'($urandom_range(0, 7));
            r   = 16'($urandom);
            a   = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'($urandom);
            model(a, w, r);
            n_vec++;
            if (oReady !== 1'b1) begin
                n_err++;
                $display("FAIL rnd_ready%0d: got %b want 1", t, oReady);
            end
            drive(sel, w, idx, r, a);
            step();
            iValid = 1'b0;
            n_vec++;
            if (sel[0] && {oRfWe, oRfIdx, oRfData, oRfWord} !== {1'b1, idx, r, w}) begin
                n_err++;
                $display("FAIL rnd_rf%0d: got we=%b idx=%0d d=%h w=%b want 1 %0d %h %b",
                         t, oRfWe, oRfIdx, oRfData, oRfWord, idx, r, w);
            end else if (!sel[0] && oRfWe !== 1'b0) begin
                n_err++;
                $display("FAIL rnd_norf%0d: got %b want 0", t, oRfWe);
            end
            if (!sel[1]) begin
                n_vec++;
                if ({oDone, oMemReq} !== 2'b10) begin
                    n_err++;
                    $display("FAIL rnd_nomem%0d: got %b want 10", t, {oDone, oMemReq});
                end
            end else begin
                first = 1'b1;
                for (int b = 0; b < m_nb; b++) begin
                    wt = $urandom_range(0, 3);
                    for (int c = 0; c <= wt; c++) begin
                        n_vec++;
                        if ({oMemReq, oMemAddr, oMemBe, oMemData, oDone, oReady}
                            !== {1'b1, m_wa[b], m_be[b], m_d[b], 1'b0, 1'b0}
                            || (!first && oRfWe !== 1'b0)) begin
                            n_err++;
                            $display("FAIL rnd_beat%0d.%0d: got req=%b a=%h be=%b d=%h done=%b rdy=%b we=%b want 1 %h %b %h 0 0",
                                     t, b, oMemReq, oMemAddr, oMemBe, oMemData, oDone,
                                     oReady, oRfWe, m_wa[b], m_be[b], m_d[b]);
                        end
                        first   = 1'b0;
                        iMemAck = (c == wt);
                        step();
                        iMemAck = 1'b0;
                    end
                end
                n_vec++;
                if ({oDone, oMemReq, oReady} !== 3'b101) begin
                    n_err++;
                    $display("FAIL rnd_done%0d: got %b want 101", t, {oDone, oMemReq, oReady});
                end
            end
        end
    endtask

    initial begin
        iRst_n  = 1'b0;
        iValid  = 1'b0;
        iSelOut = 2'd0;
        iWordOp = 1'b0;
        iRegIdx = 3'd0;
        iRes    = 16'h0;
        iAddr   = 20'h0;
        iMemAck = 1'b0;
        test_reset();
        test_rf_only();
        test_drop();
        test_byte_store();
        test_split(20'h01233, 16'hA55A, 19'h00919, 16'h5A00, 19'h0091A, 16'h00A5);
        test_split(20'hFFFFF, 16'h1357, 19'h7FFFF, 16'h5700, 19'h00000, 16'h0013);
        test_both();
        test_reset_mid();
        test_random(60);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exec_selwr.md
Name: exec_selwr

Overview:
- Write-back selector/sequencer for the exec stage; the write-side counterpart of the operand read selector.
- Takes one ALU result per transaction and routes it to the register-file write port, to the memory write bus, or to both.
- Splits odd-address word stores into two byte-lane bus cycles.
- Stalls the exec stage, via its ready output, while a memory write is outstanding.

Parameters:
- AW, 20, physical memory address width (byte address).
- DW, 16, result/data width; fixed at 16, not meant to be overridden.

Ports:
- iClk  in  1  system clock
- iRst_n  in  1  asynchronous active-low reset
- iValid  in  1  write-back request from exec
- oReady  out  1  block can accept a request this cycle
- iSelOut  in  2  destination: 0 none, 1 RF, 2 Mem, 3 RF+Mem
- iWordOp  in  1  1 = 16-bit operation, 0 = 8-bit operation
- iRegIdx  in  3  register-file destination index
- iRes  in  16  result to write
- iAddr  in  AW  byte address of the memory destination
- oRfWe  out  1  register-file write strobe (one-cycle pulse)
- oRfIdx  out  3  register-file write index
- oRfData  out  16  register-file write data
- oRfWord  out  1  register-file write size (1 word, 0 byte)
- oMemReq  out  1  memory write request
- oMemAddr  out  AW-1  word address, i.e. byte address [AW-1:1]
- oMemData  out  16  memory write data, lane-aligned
- oMemBe  out  2  byte enables: [0] low lane (even byte), [1] high lane (odd byte)
- iMemAck  in  1  memory write accepted
- oDone  out  1  one-cycle pulse when the transaction completes

Behaviour:
- Reset (async, iRst_n=0):
  - state=IDLE.
  - oReady=1; oRfWe=0; oMemReq=0; oDone=0.
  - oMemBe=0; oMemAddr, oMemData, oRfIdx, oRfData, oRfWord all 0.
- Accept: iValid & oReady at a rising edge.
  - oReady is 1 only in IDLE and is driven combinationally from state.
- RF path (iSelOut[0]=1):
  - One cycle after accept, oRfWe=1 for exactly one cycle.
  - oRfIdx=iRegIdx, oRfData=iRes, oRfWord=iWordOp, all registered at accept.
  - Independent of memory progress.
- Mem path (iSelOut[1]=1): inputs registered at accept, then state→MEM1 with oMemReq=1 from the next cycle.
  - Byte op, even address: BE=01, data={8'h00,res[7:0]}.
  - Byte op, odd address: BE=10, data={res[7:0],8'h00}.
  - Word op, even address: BE=11, data=res; single cycle.
  - Word op, odd address (split): MEM1 uses BE=10, data={res[7:0],8'h00}, word address = addr[AW-1:1]. MEM2 uses BE=01, data={8'h00,res[15:8]}, word address = addr[AW-1:1]+1, wrapping modulo 2^(AW-1) (e.g. byte address 0xFFFFF → second cycle word address 0).
- Handshake:
  - oMemReq, oMemAddr, oMemData and oMemBe stay stable until the cycle iMemAck=1 is sampled with oMemReq=1.
  - iMemAck is ignored while oMemReq=0.
  - Ack in MEM1 with split → MEM2: the next cycle oMemReq=1 again with the new address and lane (no idle gap).
  - Ack in MEM1 without split, or ack in MEM2 → IDLE, oMemReq=0, oDone=1 next cycle.
- Completion:
  - iSelOut=1 (RF only): oDone pulses in the same cycle as oRfWe; state stays IDLE, so back-to-back accepts run every cycle.
  - iSelOut=0: accepted and dropped; oDone pulses one cycle later; no strobes.
  - iSelOut=3: oRfWe fires one cycle after accept; oDone fires only after the last memory ack.
- Zero-wait memory: ack in the first cycle of oMemReq is legal. A non-split store then occupies 2 cycles from accept to oDone.
- FSM states and transitions:
  - IDLE→MEM1 on accept with mem.
  - MEM1→MEM2 on ack if split.
  - MEM1→IDLE on ack if not split.
  - MEM2→IDLE on ack.
  - No other transitions.
- Reset mid-operation: immediate return to IDLE with all strobes low; no oDone; the pending half of a split store is discarded.

Decomposition:
- Shared exec package: destination encodings SEL_NONE/SEL_RF/SEL_MEM/SEL_BOTH; state encodings IDLE/MEM1/MEM2; BE constants BE_LO=01, BE_HI=10, BE_W=11.
- One natural sub-module, exec_lane_align (combinational): maps byte address bit 0, iWordOp, phase and iRes to {oMemBe, oMemData}. The FSM and registers stay in exec_selwr.

Test Plan:
- RF-only accept with iRegIdx=3, iRes=16'hBEEF, iWordOp=1 → next cycle oRfWe=1, oRfIdx=3, oRfData=BEEF, oRfWord=1, oDone=1; oMemReq stays 0; oReady stays 1 throughout.
- Byte store, iAddr=0x00101, iRes=16'h0034, iSelOut=2, ack after 3 wait cycles → oMemAddr=0x00080, BE=10, data=3400 held stable for 4 cycles; oDone pulses 1 cycle after ack; oReady=0 until IDLE.
- Split word store, iAddr=0x01233, iRes=16'hA55A, zero-wait ack → cycle 1: addr 0x00919, BE=10, data 5A00; cycle 2: addr 0x0091A, BE=01, data 00A5; then oDone.
- Wrap: split word store at iAddr=0xFFFFF → second cycle oMemAddr=0x00000, BE=01.
- iSelOut=3, iRes=16'h1234, iAddr=0x00010, ack after 2 wait cycles → oRfWe one cycle after accept; memory word at addr 0x00008, BE=11; oDone only after the ack; a spurious iMemAck while oMemReq=0 has no effect.
- Drive iRst_n=0 during MEM2 of a split store → oMemReq drops asynchronously; no oDone; after release oReady=1 and a new RF-only request completes normally.
